// File: rtl/string_hw_pkg.sv
// Shared types and constants for the string operation engine.
// STRING_OP_STRCHR_EN (optional) enables the STRCHR operation.
package string_hw_pkg;

  localparam int DEFAULT_MAX_WORDS = 8;
  localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_STRCMP = 2'd0,
    OP_STRLEN = 2'd1,
    OP_STRCHR = 2'd2,
    OP_RSVD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/string_word_scan.sv
// Combinational evaluation of one 4-character word; the lowest terminating lane wins.
// STRING_OP_STRCHR_EN (optional) adds the character-match comparators.
module string_word_scan
  import string_hw_pkg::*;
(
  input  logic [31:0]       word_a,
  input  logic [31:0]       word_b,
  input  logic [7:0]        ch,
  input  op_t               op,
  output logic              hit,
  output logic [1:0]        hit_lane,
  output logic              hit_is_match,
  output logic signed [8:0] diff
);

  logic [3:0] term;
  logic [3:0] match;

`ifndef STRING_OP_STRCHR_EN
  logic unused_ch;
  assign unused_ch = ^ch;
`endif

  always_comb begin
    term  = '0;
    match = '0;
    for (int k = 0; k < 4; k++) begin
      case (op)
        OP_STRCMP: term[k] = (word_a[8*k +: 8] != word_b[8*k +: 8]) ||
                             (word_a[8*k +: 8] == 8'h00);
        OP_STRLEN: term[k] = (word_a[8*k +: 8] == 8'h00);
`ifdef STRING_OP_STRCHR_EN
        OP_STRCHR: begin
          match[k] = (word_a[8*k +: 8] == ch);
          term[k]  = match[k] || (word_a[8*k +: 8] == 8'h00);
        end
`endif
        default:   term[k] = 1'b0;
      endcase
    end
  end

  // Scan from the top lane down so the lowest terminating lane is the one left standing.
  always_comb begin
    hit          = 1'b0;
    hit_lane     = 2'd0;
    hit_is_match = 1'b0;
    diff         = '0;
    for (int k = 3; k >= 0; k--) begin
      if (term[k]) begin
        hit          = 1'b1;
        hit_lane     = 2'(k);
        hit_is_match = match[k];
        diff         = 9'({1'b0, word_a[8*k +: 8]}) - 9'({1'b0, word_b[8*k +: 8]});
      end
    end
  end

endmodule

// File: rtl/string_op_engine.sv
// Sequential STRCMP/STRLEN/STRCHR engine scanning one 32-bit word per cycle.
// STRING_OP_STRCHR_EN (optional) enables op=2; otherwise op=2 reports an error like op=3.
module string_op_engine
  import string_hw_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [1:0]             op,
  input  logic [7:0]             ch,
  input  logic [MAX_WORDS*32-1:0] string_a,
  input  logic [MAX_WORDS*32-1:0] string_b,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            result
);

  localparam int WI_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [WI_W-1:0] LAST_WI = WI_W'(MAX_WORDS - 1);

  state_t            state_q, state_d;
  logic [WI_W-1:0]   wi_q, wi_d;
  op_t               op_q, op_d;
  logic [31:0]       result_d;
  logic              done_d, error_d;
  logic [7:0]        scan_ch;

  logic              hit;
  logic [1:0]        hit_lane;
  logic              hit_is_match;
  logic signed [8:0] diff;
  logic              op_valid;
  logic [31:0]       hit_result;
  logic [31:0]       end_result;

`ifdef STRING_OP_STRCHR_EN
  logic [7:0] ch_q, ch_d;
  assign scan_ch  = ch_q;
  assign op_valid = (op_q == OP_STRCMP) || (op_q == OP_STRLEN) || (op_q == OP_STRCHR);
`else
  logic unused_ch;
  assign unused_ch = ^ch;
  assign scan_ch   = 8'h00;
  assign op_valid  = (op_q == OP_STRCMP) || (op_q == OP_STRLEN);
`endif

  string_word_scan u_scan (
    .word_a       (string_a[32*wi_q +: 32]),
    .word_b       (string_b[32*wi_q +: 32]),
    .ch           (scan_ch),
    .op           (op_q),
    .hit          (hit),
    .hit_lane     (hit_lane),
    .hit_is_match (hit_is_match),
    .diff         (diff)
  );

  // A lane's index is simply {word, lane}; STRCHR misses collapse to NOT_FOUND.
  always_comb begin
    hit_result = 32'({wi_q, hit_lane});
    end_result = '0;
    case (op_q)
      OP_STRCMP: begin
        hit_result = {{23{diff[8]}}, diff};
        end_result = '0;
      end
      OP_STRLEN: end_result = 32'(MAX_WORDS * 4);
      default: begin
        if (!hit_is_match) hit_result = NOT_FOUND;
        end_result = NOT_FOUND;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wi_d     = wi_q;
    op_d     = op_q;
    result_d = result;
    done_d   = done;
    error_d  = error;
`ifdef STRING_OP_STRCHR_EN
    ch_d     = ch_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d  = SCAN;
          op_d     = op_t'(op);
          wi_d     = '0;
          result_d = '0;
          done_d   = 1'b0;
          error_d  = 1'b0;
`ifdef STRING_OP_STRCHR_EN
          ch_d     = ch;
`endif
        end
      end
      SCAN: begin
        if (!op_valid) begin
          state_d  = DONE;
          done_d   = 1'b1;
          error_d  = 1'b1;
          result_d = '0;
        end else if (hit) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = hit_result;
        end else if (wi_q == LAST_WI) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = end_result;
        end else begin
          wi_d = wi_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wi_q    <= '0;
      op_q    <= OP_STRCMP;
      result  <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
`ifdef STRING_OP_STRCHR_EN
      ch_q    <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      wi_q    <= wi_d;
      op_q    <= op_d;
      result  <= result_d;
      done    <= done_d;
      error   <= error_d;
`ifdef STRING_OP_STRCHR_EN
      ch_q    <= ch_d;
`endif
    end
  end

  assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_string_op_engine.sv
// Randomized self-checking bench for string_op_engine against a string-level model.
// Honors STRING_OP_STRCHR_EN to decide whether op=2 is a valid operation.
module tb_string_op_engine;

  localparam int MW = 8;
  localparam int NB = MW * 4;

  logic            clk;
  logic            reset;
  logic            go;
  logic [1:0]      op;
  logic [7:0]      ch;
  logic [MW*32-1:0] string_a;
  logic [MW*32-1:0] string_b;
  logic            busy;
  logic            done;
  logic            error;
  logic [31:0]     result;

  int pass_count = 0;
  int total_count = 0;

  logic        check_en = 1'b0;
  logic        exp_busy, exp_done, exp_error;
  logic [31:0] exp_result;

  string_op_engine #(.MAX_WORDS(MW)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .op       (op),
    .ch       (ch),
    .string_a (string_a),
    .string_b (string_b),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      pass_count++;
  endtask

  // Reference: walk the strings character by character.
  function automatic void model(input logic [1:0] o, input logic [7:0] c,
                                input logic [MW*32-1:0] a, input logic [MW*32-1:0] b,
                                output logic [31:0] r, output logic e, output int n);
    logic [7:0] ca, cb;
    bit valid;
    e = 1'b0; r = '0; n = MW - 1;
    valid = (o == 2'd0) || (o == 2'd1);
`ifdef STRING_OP_STRCHR_EN
    if (o == 2'd2) valid = 1'b1;
`endif
    if (!valid) begin
      e = 1'b1; r = '0; n = 0;
      return;
    end
    if (o == 2'd1) r = NB;
    if (o == 2'd2) r = 32'hFFFF_FFFF;
    for (int i = 0; i < NB; i++) begin
      ca = a[8*i +: 8];
      cb = b[8*i +: 8];
      if (o == 2'd0 && (ca != cb || ca == 8'h00)) begin
        r = int'(ca) - int'(cb); n = i / 4; return;
      end
      if (o == 2'd1 && ca == 8'h00) begin
        r = i; n = i / 4; return;
      end
      if (o == 2'd2 && ca == c) begin
        r = i; n = i / 4; return;
      end
      if (o == 2'd2 && ca == 8'h00) begin
        r = 32'hFFFF_FFFF; n = i / 4; return;
      end
    end
  endfunction

  function automatic logic [MW*32-1:0] mk_str(input string s);
    logic [MW*32-1:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < NB; i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy", 32'(busy), 32'(exp_busy));
      checkOutput("done", 32'(done), 32'(exp_done));
      checkOutput("error", 32'(error), 32'(exp_error));
      checkOutput("result", result, exp_result);
    end
  end

  // Issue one operation; optionally pulse go again after ignore_at scan edges.
  task automatic applyStimulus(input logic [1:0] o, input logic [7:0] c,
                               input logic [MW*32-1:0] a, input logic [MW*32-1:0] b,
                               input int ignore_at);
    logic [31:0] r;
    logic        e;
    int          n;
    @(negedge clk);
    op = o; ch = c; string_a = a; string_b = b; go = 1'b1;
    model(o, c, a, b, r, e, n);
    @(posedge clk); #1;
    go = 1'b0;
    exp_busy = 1'b1; exp_done = 1'b0; exp_error = 1'b0; exp_result = '0;
    for (int k = 0; k <= n; k++) begin
      if (k == ignore_at) begin
        go = 1'b1;
        op = 2'($urandom_range(0, 3));
        ch = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      go = 1'b0;
      if (k == n) begin
        exp_busy = 1'b0; exp_done = 1'b1; exp_error = e; exp_result = r;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [MW*32-1:0] hello, full, ra, rb;
    logic [31:0] mr;
    logic        me;
    int          mn, len, pos;

    reset = 1'b0; go = 1'b0; op = '0; ch = '0; string_a = '0; string_b = '0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_error = 1'b0; exp_result = '0;
    #3;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    check_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    hello = mk_str("hello world");
    full  = '0;
    for (int i = 0; i < NB; i++) full[8*i +: 8] = 8'h78;

    model(2'd1, 8'h00, hello, hello, mr, me, mn);
    checkOutput("model_strlen_hello", mr, 32'd11);
    model(2'd0, 8'h00, mk_str("abc"), mk_str("abd"), mr, me, mn);
    checkOutput("model_strcmp_abc", mr, 32'hFFFF_FFFF);

    applyStimulus(2'd0, 8'h00, mk_str("abc"), mk_str("abd"), -1);
    checkOutput("t1_result", result, 32'hFFFF_FFFF);
    checkOutput("t1_error", 32'(error), 32'd0);

    applyStimulus(2'd1, 8'h00, hello, '0, -1);
    checkOutput("t2_result", result, 32'd11);

    applyStimulus(2'd2, 8'h77, hello, '0, -1);
`ifdef STRING_OP_STRCHR_EN
    checkOutput("t3_chr_w", result, 32'd6);
    applyStimulus(2'd2, 8'h7a, hello, '0, -1);
    checkOutput("t3_chr_z", result, 32'hFFFF_FFFF);
    applyStimulus(2'd2, 8'h00, hello, '0, -1);
    checkOutput("t3_chr_nul", result, 32'd11);
`else
    checkOutput("t3_chr_err", 32'(error), 32'd1);
    checkOutput("t3_chr_res", result, 32'd0);
`endif

    applyStimulus(2'd0, 8'h00, full, full, 3);
    checkOutput("t4_cmp_full", result, 32'd0);
    applyStimulus(2'd1, 8'h00, full, full, 1);
    checkOutput("t4_len_full", result, 32'd32);

    // Reset in the middle of a long scan.
    @(negedge clk);
    op = 2'd0; string_a = full; string_b = full; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    exp_busy = 1'b1; exp_done = 1'b0; exp_error = 1'b0; exp_result = '0;
    @(posedge clk); @(posedge clk);
    check_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    exp_busy = 1'b0; exp_done = 1'b0; exp_error = 1'b0; exp_result = '0;
    check_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(2'd3, 8'h00, hello, hello, -1);
    checkOutput("t6_rsvd_err", 32'(error), 32'd1);
    applyStimulus(2'd1, 8'h00, hello, hello, -1);
    checkOutput("t6_len_err", 32'(error), 32'd0);
    checkOutput("t6_len_res", result, 32'd11);

    for (int t = 0; t < 80; t++) begin
      len = $urandom_range(0, NB);
      for (int i = 0; i < NB; i++) ra[8*i +: 8] = 8'h61 + 8'($urandom_range(0, 2));
      if (len < NB) ra[8*len +: 8] = 8'h00;
      rb = ra;
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, NB - 1);
        rb[8*pos +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h61 + 8'($urandom_range(0, 2));
      end
      applyStimulus(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0) ? 8'h00 : 8'h61 + 8'($urandom_range(0, 3)),
                    ra, rb,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1);
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/string_op_engine.md
# string_op_engine

Sequential string-operation engine that sits directly downstream of the String HW Avalon register file. It consumes the StringA/StringB word arrays and the Control register fields, then scans the strings one 32-bit word (4 characters) per cycle. It produces a 32-bit result plus busy/done/error status, which the register file returns to the Nios II through the Result register.

## Interface
Parameters:
- MAX_WORDS, 8: number of 32-bit words per string; strings hold MAX_WORDS*4 characters.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low. Engine is held in reset while reset=0.
- go  in  1  start pulse; sampled only in IDLE or DONE.
- op  in  2  operation select, sampled with go:
  - 0 = STRCMP
  - 1 = STRLEN (StringA)
  - 2 = STRCHR (StringA)
  - 3 = reserved
- ch  in  8  search character for STRCHR, sampled with go.
- string_a  in  MAX_WORDS*32  StringA; word w occupies bits [32w+31:32w]; character 4w+k occupies byte lane k (bits [8k+7:8k]).
- string_b  in  MAX_WORDS*32  StringB, same packing as string_a.
- busy  out  1  high in SCAN.
- done  out  1  high in DONE; sticky until next accepted go or reset.
- error  out  1  high with done when the op was invalid.
- result  out  32  operation result; valid while done=1.

## Operation
- FSM states and transitions:
  - IDLE: waits for go.
  - SCAN: examines word index wi, which starts at 0.
  - DONE: holds result; a new go restarts the engine.
- Accepted go (in IDLE or DONE):
  - latches op and ch;
  - clears done, error and result to 0;
  - sets wi=0 and enters SCAN.
- go while busy is ignored. The latched op and ch stay unchanged.
- Each SCAN cycle evaluates the 4 lanes of word wi. The lowest terminating lane wins.
- STRCMP:
  - A lane terminates when A byte != B byte, or when A byte == 0.
  - result = zero-extended A byte minus zero-extended B byte, sign-extended to 32 bits (range -255..255).
  - If no lane terminates through word MAX_WORDS-1, result = 0.
- STRLEN:
  - A lane terminates when the A byte == 0.
  - result = 4*wi + lane.
  - If no NUL is found, result = MAX_WORDS*4.
- STRCHR:
  - A lane terminates when the A byte == ch (match) or the A byte == 0 (miss).
  - On a match, result = 4*wi + lane. On a miss or end of buffer, result = 32'hFFFF_FFFF.
  - ch == 0 returns the index of the terminating NUL.
- Termination: result is written and the FSM enters DONE. Otherwise wi increments. If wi == MAX_WORDS-1 with no termination, the end-of-buffer result is written and the FSM enters DONE.
- op == 3: no scan is performed. The FSM goes from SCAN to DONE on the first SCAN cycle with error=1 and result=0.
- Strings are read live, not snapshotted. Software must not write StringA/StringB while busy. If it does, result content is undefined, but termination within MAX_WORDS cycles is still guaranteed.
- Index arithmetic is unsigned and 32 bits wide. wi is $clog2(MAX_WORDS) bits and never wraps, because the scan stops at MAX_WORDS-1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, error=0, result=0, wi=0. Reset takes effect immediately, including mid-SCAN. No partial result survives it.
- go sampled high at edge E: busy=1 after E.
- Word n is examined at edge E+1+n.
- If word n terminates: done=1, busy=0 and result are valid after edge E+1+n.
- Latency from go to done is n+2 edges for termination in word n. Maximum is MAX_WORDS+1.
- The first SCAN word with op=3 yields done after E+1.
- done, busy and result are registered outputs with no combinational path from inputs.

## Configuration
- STRING_OP_STRCHR_EN defined: STRCHR (op=2) is implemented as above.
- Macro undefined: the STRCHR comparators and the ch register are removed. op=2 is treated exactly like op=3: done with error=1 and result=0 after one SCAN cycle.

## Structure
- Package string_hw_pkg holds:
  - the op_t enum (OP_STRCMP, OP_STRLEN, OP_STRCHR, OP_RSVD);
  - the state_t enum (IDLE, SCAN, DONE);
  - the constant NOT_FOUND = 32'hFFFF_FFFF;
  - the default MAX_WORDS.
- One sub-module, string_word_scan. It is combinational and takes one A word, one B word, ch and op. It outputs:
  - hit (1 bit);
  - hit_lane (2 bits);
  - hit_is_match (1 bit);
  - diff (9-bit signed A-B of the hit lane).
- The top level holds the FSM, wi, the latched op/ch and the output registers.

## Test plan
1. STRCMP, A="abc\0", B="abd\0" (word0 A=32'h00636261, B=32'h00646261) -> done after 2 edges, result=32'hFFFF_FFFF (-1), error=0.
2. STRLEN, A="hello world\0" (NUL at index 11) -> word 2 terminates, done after 4 edges, result=11.
3. STRCHR ch='w', same A -> result=6. With ch='z' -> result=32'hFFFF_FFFF. Rerun with the macro undefined and op=2 -> error=1, result=0.
4. STRCMP with MAX_WORDS=8, both strings 32 identical non-NUL bytes -> done after 9 edges, result=0. STRLEN on the same A -> result=32.
5. go pulsed again at cycle 2 of a 9-cycle scan -> ignored, result unchanged. reset driven low mid-SCAN -> busy=0, done=0, result=0 immediately.
6. op=3 -> done after 2 edges with error=1. A subsequent go with op=1 clears error and done on accept and then returns a valid STRLEN.
